// File: rtl/mmio_bus_master_pkg.sv
// Shared types for the MMIO bus master: FSM states, request/response records,
// the Mem_ift channel payloads and the address alignment helper.
package MMIOMasterStruct;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } MMIOReq;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } MMIOResp;

    // Master read request channel
    typedef struct packed {
        logic        ren;
        logic [63:0] raddr;
    } mem_mr_t;

    // Master write request channel
    typedef struct packed {
        logic        wen;
        logic [63:0] waddr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } mem_mw_t;

    // Slave read return channel
    typedef struct packed {
        logic [63:0] rdata;
        logic        rvalid;
    } mem_sr_t;

    // Slave write acknowledge channel
    typedef struct packed {
        logic wvalid;
    } mem_sw_t;

    localparam logic [2:0] ALIGN_MASK = 3'b111;

    // Accesses are doubleword only; any low address bit set is rejected.
    function automatic logic is_misaligned(input logic [63:0] addr);
        return (addr[2:0] & ALIGN_MASK) != 3'b000;
    endfunction

endpackage

// File: rtl/mmio_bus_master_if.sv
// Mem_ift: the MMIO bus between one initiator and a slave such as the machine
// timer. Mr/Mw are driven by the master, Sr/Sw are returned by the slave.
interface Mem_ift;
    import MMIOMasterStruct::*;

    mem_mr_t Mr;
    mem_mw_t Mw;
    mem_sr_t Sr;
    mem_sw_t Sw;

    modport Master (output Mr, output Mw, input Sr, input Sw);
    modport Slave  (input Mr, input Mw, output Sr, output Sw);

endinterface

// File: rtl/mmio_bus_master_wait_timer.sv
// mmio_wait_timer: counts cycles spent waiting for a slave handshake and flags
// the last permitted cycle. Only instantiated when MMIO_BUS_TIMEOUT_EN is set.
module mmio_wait_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    logic [15:0] count;

    // Counter sits at zero outside a wait and advances once per waiting cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    assign expired = run && (count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mmio_bus_master.sv
// mmio_bus_master: initiator side of Mem_ift. Takes one load/store at a time
// from the core MMIO path, runs a single bus read or write and returns a
// one-cycle response. Every output comes straight from a flop.
// Optional build macro: MMIO_BUS_TIMEOUT_EN enables the TIMEOUT_CYCLES limit
// and aborts a wait that sees no rvalid/wvalid in time.
module mmio_bus_master
   import MMIOMasterStruct::*;
#(
   parameter int TIMEOUT_CYCLES = 256
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [63:0]   req_addr,
   input  logic [63:0]   req_wdata,
   input  logic [7:0]    req_wmask,
   output logic          resp_valid,
   output logic [63:0]   resp_rdata,
   output logic          resp_err,
   output logic          busy,
   Mem_ift.Master        mem_ift
);

   state_e  state, stateN;
   MMIOReq  reqQ, reqN;
   MMIOResp respQ, respN;
   logic    respValidQ, respValidN;
   logic    renQ, renN;
   logic    wenQ, wenN;
   logic    busyQ, busyN;
   logic    readyQ, readyN;
   logic    done;

`ifdef MMIO_BUS_TIMEOUT_EN
   logic expired;

   mmio_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) uWaitTimer (
      .clk     (clk),
      .rst     (rst),
      .run     ((state == RD) || (state == WR)),
      .expired (expired)
   );
`endif

   // Next state plus the next value of every registered output.
   always_comb begin
      stateN = state;
      reqN   = reqQ;
      respN  = respQ;
      done   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               reqN.we    = req_we;
               reqN.addr  = req_addr;
               reqN.wdata = req_wdata;
               reqN.wmask = req_wmask;
               respN      = '0;
               if (is_misaligned(req_addr)) begin
                  respN.err = 1'b1;
                  stateN    = RESP;
               end else if (req_we) begin
                  stateN = WR;
               end else begin
                  stateN = RD;
               end
            end
         end
         RD, WR: begin
            done = reqQ.we ? mem_ift.Sw.wvalid : mem_ift.Sr.rvalid;
            if (done) begin
               respN       = '0;
               respN.rdata = reqQ.we ? 64'd0 : mem_ift.Sr.rdata;
               stateN      = RESP;
            end
`ifdef MMIO_BUS_TIMEOUT_EN
            else if (expired) begin
               respN     = '0;
               respN.err = 1'b1;
               stateN    = RESP;
            end
`endif
         end
         RESP: begin
            respN  = '0;
            stateN = IDLE;
         end
         default: begin
            stateN = IDLE;
         end
      endcase
      respValidN = (stateN == RESP);
      renN       = (stateN == RD);
      wenN       = (stateN == WR);
      busyN      = (stateN != IDLE);
      readyN     = (stateN == IDLE);
   end

   // State and output registers; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         reqQ       <= '0;
         respQ      <= '0;
         respValidQ <= 1'b0;
         renQ       <= 1'b0;
         wenQ       <= 1'b0;
         busyQ      <= 1'b0;
         readyQ     <= 1'b1;
      end else begin
         state      <= stateN;
         reqQ       <= reqN;
         respQ      <= respN;
         respValidQ <= respValidN;
         renQ       <= renN;
         wenQ       <= wenN;
         busyQ      <= busyN;
         readyQ     <= readyN;
      end
   end

   assign req_ready  = readyQ;
   assign busy       = busyQ;
   assign resp_valid = respValidQ;
   assign resp_rdata = respQ.rdata;
   assign resp_err   = respQ.err;

   assign mem_ift.Mr = '{ren: renQ, raddr: reqQ.addr};
   assign mem_ift.Mw = '{wen: wenQ, waddr: reqQ.addr, wdata: reqQ.wdata, wmask: reqQ.wmask};

endmodule

// File: tb/tb_mmio_bus_master.sv
// Directed bench for mmio_bus_master: aligned load, waited store, misaligned
// access, timeout (or endless wait), reset mid-access and back-to-back requests.
module tb_mmio_bus_master;
   import MMIOMasterStruct::*;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   int total;
   int bad;

   Mem_ift bus ();

   mmio_bus_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wmask  (req_wmask),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy),
      .mem_ift    (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one cycle; sampling and driving happen 1 unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic we, input logic [63:0] a,
                                input logic [63:0] wd, input logic [7:0] m);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      req_wmask = m;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
         $error("[TB] check %s", tag);
      end
   endtask

   logic [63:0] b2bAddr  [3];
   logic        b2bWe    [3];
   logic [63:0] b2bWdata [3];
   logic [7:0]  b2bMask  [3];
   logic [63:0] b2bRdv   [3];
   int          accCyc   [3];
   int          rspCyc   [3];
   int          renCnt;
   int          k;
   int          r;
   int          last;
   logic        seen;

   // Main directed sequence: each scenario drives stimulus and checks outputs.
   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
      bus.Sr.rdata  = 64'd0;
      bus.Sr.rvalid = 1'b0;
      bus.Sw.wvalid = 1'b0;
      repeat (2) tick();

      checkOutput("rst_ready", req_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_ren", bus.Mr.ren, 0);
      checkOutput("rst_wen", bus.Mw.wen, 0);
      rst = 1'b0;
      tick();

      $display("[TB] aligned load");
      bus.Sr.rdata  = 64'h1234;
      bus.Sr.rvalid = 1'b1;
      applyStimulus(1'b1, 1'b0, 64'h0200_BFF8, 64'd0, 8'd0);
      checkOutput("ld_ready_n", req_ready, 1);
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
      checkOutput("ld_ren_n1", bus.Mr.ren, 1);
      checkOutput("ld_raddr_n1", bus.Mr.raddr, 64'h0200_BFF8);
      checkOutput("ld_wen_n1", bus.Mw.wen, 0);
      checkOutput("ld_resp_n1", resp_valid, 0);
      checkOutput("ld_busy_n1", busy, 1);
      checkOutput("ld_ready_n1", req_ready, 0);
      tick();
      checkOutput("ld_resp_n2", resp_valid, 1);
      checkOutput("ld_rdata_n2", resp_rdata, 64'h1234);
      checkOutput("ld_err_n2", resp_err, 0);
      checkOutput("ld_ren_n2", bus.Mr.ren, 0);
      tick();
      checkOutput("ld_resp_n3", resp_valid, 0);
      checkOutput("ld_ready_n3", req_ready, 1);
      checkOutput("ld_busy_n3", busy, 0);
      bus.Sr.rvalid = 1'b0;
      bus.Sr.rdata  = 64'd0;

      $display("[TB] waited store");
      applyStimulus(1'b1, 1'b1, 64'h0200_4000, 64'hDEAD_BEEF, 8'h0F);
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("st_wen", bus.Mw.wen, 1);
         checkOutput("st_ren", bus.Mr.ren, 0);
         checkOutput("st_waddr", bus.Mw.waddr, 64'h0200_4000);
         checkOutput("st_wdata", bus.Mw.wdata, 64'hDEAD_BEEF);
         checkOutput("st_wmask", bus.Mw.wmask, 8'h0F);
         checkOutput("st_no_resp", resp_valid, 0);
         if (i == 3) bus.Sw.wvalid = 1'b1;
         tick();
      end
      checkOutput("st_resp", resp_valid, 1);
      checkOutput("st_err", resp_err, 0);
      checkOutput("st_rdata", resp_rdata, 0);
      checkOutput("st_wen_off", bus.Mw.wen, 0);
      bus.Sw.wvalid = 1'b0;
      tick();
      checkOutput("st_resp_once", resp_valid, 0);

      $display("[TB] misaligned load");
      applyStimulus(1'b1, 1'b0, 64'h0200_4003, 64'd0, 8'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
      checkOutput("mis_resp", resp_valid, 1);
      checkOutput("mis_err", resp_err, 1);
      checkOutput("mis_rdata", resp_rdata, 0);
      checkOutput("mis_ren", bus.Mr.ren, 0);
      checkOutput("mis_wen", bus.Mw.wen, 0);
      tick();
      checkOutput("mis_resp_off", resp_valid, 0);
      checkOutput("mis_ren_after", bus.Mr.ren, 0);
      checkOutput("mis_ready", req_ready, 1);

      $display("[TB] silent slave");
      bus.Sr.rdata = 64'hFFFF;
      applyStimulus(1'b1, 1'b0, 64'h0200_0008, 64'd0, 8'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
`ifdef MMIO_BUS_TIMEOUT_EN
      renCnt = 0;
      for (int c = 0; c < 30 && !resp_valid; c++) begin
         if (bus.Mr.ren) renCnt++;
         tick();
      end
      checkOutput("to_resp", resp_valid, 1);
      checkOutput("to_ren_cycles", 64'(renCnt), 8);
      checkOutput("to_err", resp_err, 1);
      checkOutput("to_rdata", resp_rdata, 0);
      checkOutput("to_ren_off", bus.Mr.ren, 0);
      tick();
      applyStimulus(1'b1, 1'b0, 64'h0200_0010, 64'd0, 8'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
      repeat (2) tick();
`else
      seen = 1'b0;
      repeat (1000) begin
         tick();
         if (resp_valid) seen = 1'b1;
      end
      checkOutput("hang_busy", busy, 1);
      checkOutput("hang_ren", bus.Mr.ren, 1);
      checkOutput("hang_no_resp", seen, 0);
`endif

      $display("[TB] reset during read wait");
      checkOutput("rw_ren_before", bus.Mr.ren, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rw_ren", bus.Mr.ren, 0);
      checkOutput("rw_busy", busy, 0);
      checkOutput("rw_ready", req_ready, 1);
      checkOutput("rw_resp", resp_valid, 0);
      bus.Sr.rvalid = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         tick();
         if (resp_valid) seen = 1'b1;
      end
      checkOutput("rw_no_resp", seen, 0);
      bus.Sr.rvalid = 1'b0;

      $display("[TB] back-to-back");
      b2bWe[0] = 1'b0; b2bAddr[0] = 64'h100; b2bWdata[0] = 64'd0;    b2bMask[0] = 8'h00; b2bRdv[0] = 64'h0000_00AA_0000_0100;
      b2bWe[1] = 1'b1; b2bAddr[1] = 64'h108; b2bWdata[1] = 64'h55AA; b2bMask[1] = 8'hFF; b2bRdv[1] = 64'd0;
      b2bWe[2] = 1'b0; b2bAddr[2] = 64'h110; b2bWdata[2] = 64'd0;    b2bMask[2] = 8'h00; b2bRdv[2] = 64'h0000_00CC_0000_0110;
      for (int i = 0; i < 3; i++) begin
         accCyc[i] = -1;
         rspCyc[i] = -1;
      end
      bus.Sr.rvalid = 1'b1;
      bus.Sw.wvalid = 1'b1;
      k    = 0;
      r    = 0;
      last = 0;
      for (int c = 0; c < 12; c++) begin
         if (k < 3) applyStimulus(1'b1, b2bWe[k], b2bAddr[k], b2bWdata[k], b2bMask[k]);
         else       applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
         bus.Sr.rdata = b2bRdv[last];
         if (resp_valid) begin
            if (r < 3) begin
               checkOutput("b2b_rdata", resp_rdata, b2bRdv[r]);
               checkOutput("b2b_err", resp_err, 0);
               rspCyc[r] = c;
            end
            r++;
         end
         if (req_ready && k < 3) begin
            accCyc[k] = c;
            last      = k;
            k++;
         end
         tick();
      end
      checkOutput("b2b_resp_count", 64'(r), 3);
      checkOutput("b2b_acc0", 64'(accCyc[0]), 0);
      checkOutput("b2b_acc1", 64'(accCyc[1]), 3);
      checkOutput("b2b_acc2", 64'(accCyc[2]), 6);
      checkOutput("b2b_rsp0", 64'(rspCyc[0]), 2);
      checkOutput("b2b_rsp1", 64'(rspCyc[1]), 5);
      checkOutput("b2b_rsp2", 64'(rspCyc[2]), 8);
      bus.Sr.rvalid = 1'b0;
      bus.Sw.wvalid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
